// File: rtl/fetch_queue.sv
// Instruction fetch queue: walks a PC through a combinational instruction memory and buffers {pc, instr} pairs for decode.
// Optional stall counter enabled by defining FETCH_QUEUE_STALL_CNT_EN.
module fetch_queue #(
  parameter int ADDR_W  = 10,
  parameter int INSTR_W = 16,
  parameter int DEPTH   = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               fetch_en,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
`ifdef FETCH_QUEUE_STALL_CNT_EN
  output logic [15:0]        stall_cnt,
`endif
  output logic [ADDR_W-1:0]  out_pc
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               push, pop;

  logic [INSTR_W-1:0] instr_mem_q [DEPTH];
  logic [ADDR_W-1:0]  pc_mem_q    [DEPTH];

  // Push eligibility looks only at the start-of-cycle count, so a full queue never refills in the cycle it pops.
  always_comb begin
    push     = fetch_en && !redirect_valid && (count_q != FULL);
    pop      = (count_q != '0) && out_ready && !redirect_valid;
    pc_d     = pc_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (redirect_valid) begin
      pc_d     = redirect_pc;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        pc_d     = pc_q + ADDR_W'(1);
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      unique case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q     <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      pc_q     <= pc_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage carries no reset; the empty-queue masking below keeps it invisible.
  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem_q[wr_ptr_q] <= imem_rdata;
      pc_mem_q[wr_ptr_q]    <= pc_q;
    end
  end

  assign imem_addr = pc_q;
  assign out_valid = (count_q != '0);
  assign out_instr = out_valid ? instr_mem_q[rd_ptr_q] : '0;
  assign out_pc    = out_valid ? pc_mem_q[rd_ptr_q]    : '0;

`ifdef FETCH_QUEUE_STALL_CNT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (redirect_valid) begin
      stall_cnt_d = '0;
    end else if (out_valid && !out_ready && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: a scoreboard of expected fetch addresses is filled as each scenario is set up
// and drained against every decode handshake.
module tb_fetch_queue;

  localparam int ADDR_W  = 10;
  localparam int INSTR_W = 16;
  localparam int DEPTH   = 4;

  logic               clk;
  logic               reset;
  logic               fetch_en;
  logic [ADDR_W-1:0]  imem_addr;
  logic [INSTR_W-1:0] imem_rdata;
  logic               redirect_valid;
  logic [ADDR_W-1:0]  redirect_pc;
  logic               out_valid;
  logic               out_ready;
  logic [INSTR_W-1:0] out_instr;
  logic [ADDR_W-1:0]  out_pc;
`ifdef FETCH_QUEUE_STALL_CNT_EN
  logic [15:0]        stall_cnt;
`endif

  int n_assert = 0;
  int n_fail   = 0;
  int ticks;
  logic [ADDR_W-1:0] sb [$];

  fetch_queue #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .DEPTH(DEPTH)) dut (
    .clk(clk),
    .reset(reset),
    .fetch_en(fetch_en),
    .imem_addr(imem_addr),
    .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_instr(out_instr),
`ifdef FETCH_QUEUE_STALL_CNT_EN
    .stall_cnt(stall_cnt),
`endif
    .out_pc(out_pc)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Instruction memory contents: unique per address.
  function automatic logic [INSTR_W-1:0] mem_fn(input logic [ADDR_W-1:0] a);
    return {a[3:0], 2'b10, a} ^ 16'h5A5A;
  endfunction

  assign imem_rdata = mem_fn(imem_addr);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare a handshaking head against the scoreboard, then advance one cycle.
  task automatic tick();
    logic [ADDR_W-1:0] exp_pc;
    if (out_valid && out_ready && !redirect_valid) begin
      n_assert++;
      assert (sb.size() != 0) else begin
        n_fail++;
        $error("FAIL unexpected_out observed_pc=%0h expected=none", out_pc);
      end
      if (sb.size() != 0) begin
        exp_pc = sb.pop_front();
        chk("out_pc", 32'(out_pc), 32'(exp_pc));
        chk("out_instr", 32'(out_instr), 32'(mem_fn(exp_pc)));
      end
    end
    @(negedge clk);
  endtask

  task automatic drain(input int budget, output int n);
    n = 0;
    while (sb.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    chk("drain_left", 32'(sb.size()), 32'd0);
  endtask

  task automatic do_reset();
    reset          = 1'b1;
    fetch_en       = 1'b0;
    out_ready      = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    sb.delete();
  endtask

  initial begin
    reset          = 1'b1;
    fetch_en       = 1'b1;
    out_ready      = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_pc", 32'(out_pc), 32'd0);
    chk("rst_out_instr", 32'(out_instr), 32'd0);
    chk("rst_imem_addr", 32'(imem_addr), 32'd0);
    @(negedge clk);
    chk("rst_edge_no_push", 32'(out_valid), 32'd0);

    // Streaming from reset: first output appears on the second cycle, one per cycle.
    do_reset();
    fetch_en  = 1'b1;
    out_ready = 1'b1;
    chk("stream_first_empty", 32'(out_valid), 32'd0);
    for (int i = 0; i < 4; i++) sb.push_back(ADDR_W'(i));
    drain(20, ticks);
    chk("stream_ticks", 32'(ticks), 32'd5);

    // Backpressure: queue fills, PC parks at 4, then a gapless drain.
    do_reset();
    fetch_en  = 1'b1;
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    chk("bp_out_valid", 32'(out_valid), 32'd1);
    chk("bp_out_pc", 32'(out_pc), 32'd0);
    chk("bp_pc_hold", 32'(imem_addr), 32'd4);
    for (int i = 0; i < 9; i++) sb.push_back(ADDR_W'(i));
    out_ready = 1'b1;
    tick();
    chk("full_pop_no_push", 32'(imem_addr), 32'd4);
    drain(30, ticks);
    chk("bp_gapless", 32'(ticks), 32'd8);

    // Redirect with three entries queued: stale entries flushed.
    do_reset();
    fetch_en  = 1'b1;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    chk("pre_redir_pc", 32'(imem_addr), 32'd3);
    chk("pre_redir_head", 32'(out_pc), 32'd0);
    redirect_valid = 1'b1;
    redirect_pc    = ADDR_W'(3);
    out_ready      = 1'b1;
    sb.delete();
    tick();
    redirect_valid = 1'b0;
    chk("redir_flush_valid", 32'(out_valid), 32'd0);
    sb.push_back(ADDR_W'(3));
    sb.push_back(ADDR_W'(4));
    sb.push_back(ADDR_W'(5));
    drain(20, ticks);
    chk("redir_ticks", 32'(ticks), 32'd4);

    // Redirect to the top address: PC wraps to 0.
    redirect_valid = 1'b1;
    redirect_pc    = ADDR_W'(1023);
    sb.delete();
    tick();
    redirect_valid = 1'b0;
    chk("wrap_flush_valid", 32'(out_valid), 32'd0);
    sb.push_back(ADDR_W'(1023));
    sb.push_back(ADDR_W'(0));
    sb.push_back(ADDR_W'(1));
    drain(20, ticks);
    chk("wrap_ticks", 32'(ticks), 32'd4);

    // fetch_en low: PC holds, queue still drains.
    do_reset();
    fetch_en  = 1'b1;
    out_ready = 1'b0;
    tick();
    tick();
    fetch_en = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    chk("hold_pc", 32'(imem_addr), 32'd2);
    chk("hold_head", 32'(out_pc), 32'd0);
    out_ready = 1'b1;
    sb.push_back(ADDR_W'(0));
    sb.push_back(ADDR_W'(1));
    drain(20, ticks);
    chk("hold_drain_ticks", 32'(ticks), 32'd2);
    tick();
    chk("hold_empty", 32'(out_valid), 32'd0);
    chk("hold_pc_after", 32'(imem_addr), 32'd2);

    // Asynchronous reset mid-cycle with two entries queued.
    do_reset();
    fetch_en  = 1'b1;
    out_ready = 1'b0;
    tick();
    tick();
    chk("pre_areset_valid", 32'(out_valid), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("areset_valid", 32'(out_valid), 32'd0);
    chk("areset_pc", 32'(imem_addr), 32'd0);
    @(negedge clk);
    reset     = 1'b0;
    out_ready = 1'b1;
    sb.delete();
    sb.push_back(ADDR_W'(0));
    sb.push_back(ADDR_W'(1));
    drain(20, ticks);
    chk("areset_ticks", 32'(ticks), 32'd3);

`ifdef FETCH_QUEUE_STALL_CNT_EN
    do_reset();
    chk("stall_rst", 32'(stall_cnt), 32'd0);
    fetch_en  = 1'b1;
    out_ready = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) tick();
    chk("stall_cnt5", 32'(stall_cnt), 32'd5);
    redirect_valid = 1'b1;
    redirect_pc    = '0;
    tick();
    redirect_valid = 1'b0;
    chk("stall_redir_clr", 32'(stall_cnt), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, meaning instruction address width in words.
REQ-002 SHALL have parameter INSTR_W, default 16, meaning instruction width.
REQ-003 SHALL have parameter DEPTH, default 4, meaning queue entries (power of two, 2..16).
REQ-004 SHALL have port clk, input, 1, meaning the single clock; all state on rising edge.
REQ-005 SHALL have port reset, input, 1, meaning asynchronous, active-high reset.
REQ-006 SHALL have port fetch_en, input, 1, meaning fetch permitted when high.
REQ-007 SHALL have port imem_addr, output, ADDR_W, meaning word address driven to the combinational instruction memory.
REQ-008 SHALL have port imem_rdata, input, INSTR_W, meaning instruction returned for imem_addr in the same cycle.
REQ-009 SHALL have port redirect_valid, input, 1, meaning branch/jump taken; flush and refetch.
REQ-010 SHALL have port redirect_pc, input, ADDR_W, meaning new fetch address.
REQ-011 SHALL have port out_valid, output, 1, meaning head entry valid to decode.
REQ-012 SHALL have port out_ready, input, 1, meaning decode accepts head this cycle.
REQ-013 SHALL have port out_instr, output, INSTR_W, meaning head instruction.
REQ-014 SHALL have port out_pc, output, ADDR_W, meaning address of out_instr.

Function
REQ-015 SHALL hold a fetch PC register; imem_addr = PC combinationally.
REQ-016 SHALL push {PC, imem_rdata} and increment PC by 1 in any cycle with fetch_en=1, redirect_valid=0, count<DEPTH.
REQ-017 SHALL wrap PC from 2^ADDR_W-1 to 0 with no flag or stall.
REQ-018 SHALL pop head in any cycle with out_valid=1, out_ready=1, redirect_valid=0.
REQ-019 SHALL evaluate push eligibility on count at start of cycle; a pop in a full cycle does not permit a same-cycle push.
REQ-020 SHALL allow simultaneous push and pop when 0<count<DEPTH; count unchanged.
REQ-021 SHALL drive out_valid = (count!=0), registered state only; out_instr/out_pc stable while out_valid=1 and out_ready=0.
REQ-022 SHALL on redirect_valid=1: clear count, rd/wr pointers to 0, PC <= redirect_pc, no push, no pop; out_valid=0 the following cycle.
REQ-023 SHALL push first instruction at redirect_pc in the cycle after redirect, if fetch_en=1; out_valid rises two cycles after redirect.
REQ-024 SHALL with fetch_en=0 hold PC and stop pushing; pops continue until empty.
REQ-025 SHALL ignore out_ready when out_valid=0.

Reset
REQ-026 SHALL on reset assertion immediately set PC=0, count=0, pointers=0, out_valid=0; out_instr and out_pc read 0.
REQ-027 SHALL on reset mid-operation discard all queued entries; first fetch after release is address 0.
REQ-028 SHALL perform no push or pop in the first clock edge while reset is high.

Configuration
REQ-029 SHALL, when macro FETCH_QUEUE_STALL_CNT_EN is defined, add output stall_cnt, 16 bits, incremented per cycle with out_valid=1 and out_ready=0, saturating at 16'hFFFF, cleared by reset and by redirect_valid.
REQ-030 SHALL, without FETCH_QUEUE_STALL_CNT_EN, omit port stall_cnt and its logic; all other behaviour identical.

Verification
REQ-031 SHALL cover reset release, fetch_en=1, out_ready=1: out_pc sequence 0,1,2,3 from cycle 2, out_instr = memory[out_pc], one per cycle.
REQ-032 SHALL cover out_ready=0 for 10 cycles: count reaches 4, PC holds at 4, out_pc stays 0; then out_ready=1 yields 0,1,2,3,4 with no gap or duplicate.
REQ-033 SHALL cover redirect_valid=1, redirect_pc=3 while count=3: next cycle out_valid=0; following cycle out_pc=3; stale entries never appear.
REQ-034 SHALL cover redirect_pc=1023 with out_ready=1: out_pc sequence 1023,0,1.
REQ-035 SHALL cover reset asserted asynchronously mid-cycle with count=2: out_valid=0 before the next edge; after release out_pc=0.
REQ-036 SHALL cover, with FETCH_QUEUE_STALL_CNT_EN, out_valid=1 and out_ready=0 for 5 cycles: stall_cnt=5; redirect -> stall_cnt=0.
